// File: rtl/aes128_encrypt_core_if.sv
// Plaintext-in / ciphertext-out handshake bundle for the AES-128 encrypt core.
interface aes128_encrypt_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  modport master (
    output in_valid, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor, one full round per clock; ciphertext is valid 10 edges after accept.
// Result is held until out_ready; in_ready is high only while idle, so upstream stalls otherwise.

module aes_sbox (
  input  logic [31:0] sboxw,
  output logic [31:0] new_sboxw
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]],
                      SBOX[sboxw[15:8]],  SBOX[sboxw[7:0]]};
endmodule

module aes128_encrypt_core (
  input  logic                  clk,
  input  logic                  reset,
  aes128_encrypt_core_if.slave  bus,
  input  logic [127:0]          k0,
  input  logic [127:0]          k1,
  input  logic [127:0]          k2,
  input  logic [127:0]          k3,
  input  logic [127:0]          k4,
  input  logic [127:0]          k5,
  input  logic [127:0]          k6,
  input  logic [127:0]          k7,
  input  logic [127:0]          k8,
  input  logic [127:0]          k9,
  input  logic [127:0]          k10
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state;
  logic [127:0] ciphertext;
  logic         out_valid;

  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [127:0] round_key;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row 0 is the MSB byte of the column word.
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    aes_sbox u_sbox (
      .sboxw     (state[127-32*c -: 32]),
      .new_sboxw (sub_bytes[127-32*c -: 32])
    );
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
  end

  always_comb begin
    round_key = '0;
    case (round)
      4'd1:    round_key = k1;
      4'd2:    round_key = k2;
      4'd3:    round_key = k3;
      4'd4:    round_key = k4;
      4'd5:    round_key = k5;
      4'd6:    round_key = k6;
      4'd7:    round_key = k7;
      4'd8:    round_key = k8;
      4'd9:    round_key = k9;
      4'd10:   round_key = k10;
      default: round_key = '0;
    endcase
  end

  assign round_out = ((round == 4'd10) ? shift_rows : mix_cols) ^ round_key;

  assign bus.in_ready   = (fsm == IDLE);
  assign bus.out_valid  = out_valid;
  assign bus.ciphertext = ciphertext;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      round      <= 4'd0;
      state      <= '0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            state <= bus.plaintext ^ k0;
            round <= 4'd1;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          state <= round_out;
          if (round == 4'd10) begin
            ciphertext <= round_out;
            out_valid  <= 1'b1;
            round      <= 4'd0;
            fsm        <= DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed and random checks of aes128_encrypt_core against a byte-level GF(2^8) AES model.
module tb_aes128_encrypt_core;
  logic clk = 1'b0;
  logic reset;
  logic [127:0] kk [11];

  aes128_encrypt_core_if bus();

  aes128_encrypt_core dut (
    .clk(clk), .reset(reset), .bus(bus),
    .k0(kk[0]), .k1(kk[1]), .k2(kk[2]), .k3(kk[3]), .k4(kk[4]), .k5(kk[5]),
    .k6(kk[6]), .k7(kk[7]), .k8(kk[8]), .k9(kk[9]), .k10(kk[10])
  );

  always #5 clk = ~clk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  int checks = 0;
  int errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] model_rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ model_rk[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++)
            t[r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4]) ^
                   s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
          for (int r = 0; r < 4; r++) s[4*c+r] = t[r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ model_rk[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    expand_key(key);
    for (int r = 0; r < 11; r++) kk[r] = model_rk[r];
  endtask

  task automatic accept(input logic [127:0] pt);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.plaintext = pt;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("accept_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int pre;
    bit ok;
    bit bad;
    logic [127:0] key, pt;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.plaintext = '0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < 11; r++) kk[r] = '0;
    build_sbox();

    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_ciphertext", bus.ciphertext, 128'd0);

    // FIPS-197 C.1
    set_key(C1_KEY);
    accept(C1_PT);
    wait_done(lat, ok);
    chk("c1_latency", 128'(lat), 128'd10);
    chk("c1_busy_ready", 128'(ok), 128'd1);
    chk("c1_ct", bus.ciphertext, C1_CT);
    drain();
    chk("c1_drain_valid", 128'(bus.out_valid), 128'd0);
    chk("c1_drain_ready", 128'(bus.in_ready), 128'd1);

    // Appendix B, first-round state and output backpressure
    set_key(B_KEY);
    accept(B_PT);
    tick();
    chk("b_state_e1", dut.state, B_R1);
    wait_done(lat, ok);
    chk("b_latency", 128'(lat + 1), 128'd10);
    chk("b_ct", bus.ciphertext, B_CT);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.ciphertext !== B_CT || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    chk("bp_stable", 128'(bad), 128'd0);
    drain();
    chk("bp_release_valid", 128'(bus.out_valid), 128'd0);
    chk("bp_release_ready", 128'(bus.in_ready), 128'd1);

    // Input offered mid-operation must be ignored
    set_key(C1_KEY);
    accept(C1_PT);
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid  = 1'b1;
    bus.plaintext = B_PT;
    tick();
    bus.in_valid  = 1'b0;
    pre = 5;
    wait_done(lat, ok);
    chk("ign_latency", 128'(lat + pre), 128'd10);
    chk("ign_ct", bus.ciphertext, C1_CT);
    drain();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
    end
    chk("ign_no_second", 128'(bad), 128'd0);

    // Back-to-back with in_valid and out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.plaintext = C1_PT;
    tick();
    wait_done(lat, ok);
    chk("b2b_lat1", 128'(lat), 128'd10);
    chk("b2b_ct1", bus.ciphertext, C1_CT);
    tick();
    chk("b2b_idle_valid", 128'(bus.out_valid), 128'd0);
    chk("b2b_idle_ready", 128'(bus.in_ready), 128'd1);
    set_key(B_KEY);
    bus.plaintext = B_PT;
    tick();
    chk("b2b_accept2", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b0;
    wait_done(lat, ok);
    chk("b2b_lat2", 128'(lat), 128'd10);
    chk("b2b_ct2", bus.ciphertext, B_CT);
    tick();
    bus.out_ready = 1'b0;

    // Random keys and plaintexts against the model, with random output stalls
    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      accept(pt);
      wait_done(lat, ok);
      chk("rnd_latency", 128'(lat), 128'd10);
      chk("rnd_ct", bus.ciphertext, aes_model(pt));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
      chk("rnd_hold", 128'(bus.out_valid), 128'd1);
      drain();
    end

    // Reset at round 6 aborts the operation
    set_key(C1_KEY);
    accept(C1_PT);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_ct", bus.ciphertext, 128'd0);
    chk("mid_rst_ready", 128'(bus.in_ready), 128'd1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("mid_rst_no_partial", 128'(bad), 128'd0);
    accept(C1_PT);
    wait_done(lat, ok);
    chk("post_rst_ct", bus.ciphertext, C1_CT);

    // Reset while holding a result in DONE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("done_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("done_rst_ct", bus.ciphertext, 128'd0);
    chk("done_rst_ready", 128'(bus.in_ready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
